// File: rtl/knight_pkg.sv
// Shared types and constants for the knight-move sequencing logic.
// Imported by the move sequencer and its forward-speed ramp.
package knight_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_RAMP_UP,
      ST_CRUISE,
      ST_RAMP_DN
   } move_state_t;

   localparam logic [3:0]  OP_MOVE        = 4'h2;
   localparam logic [9:0]  DEF_MAX_SPD    = 10'h2A0;
   localparam logic [11:0] DEF_ERR_THRESH = 12'h030;

endpackage

// File: rtl/frwrd_ramp.sv
// Saturating up/down forward-speed accumulator, stepped on heading_rdy.
// Ramp-down uses twice the ramp-up step.
module frwrd_ramp #(
   parameter logic [9:0] STEP    = 10'h004,
   parameter logic [9:0] MAX_SPD = 10'h2A0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       inc,
   input  logic       dec,
   input  logic       clr,
   output logic [9:0] frwrd,
   output logic       at_max,
   output logic       at_zero,
   output logic       hit_max
);

   logic [10:0] sum_up;
   logic [10:0] dstep;
   logic [10:0] diff_dn;
   logic        sat_up;
   logic        sat_dn;

   assign sum_up  = {1'b0, frwrd} + {1'b0, STEP};
   assign dstep   = {STEP, 1'b0};
   assign diff_dn = {1'b0, frwrd} - dstep;
   assign sat_up  = sum_up >= {1'b0, MAX_SPD};
   assign sat_dn  = {1'b0, frwrd} <= dstep;

   // Flags the update that lands on MAX_SPD so the FSM moves in the same edge.
   assign hit_max = en & inc & sat_up;
   assign at_max  = frwrd == MAX_SPD;
   assign at_zero = frwrd == 10'h000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         frwrd <= 10'h000;
      else if (clr)
         frwrd <= 10'h000;
      else if (en && inc)
         frwrd <= sat_up ? MAX_SPD : sum_up[9:0];
      else if (en && dec)
         frwrd <= sat_dn ? 10'h000 : diff_dn[9:0];
   end

endmodule

// File: rtl/move_seq.sv
// Knight-move leg sequencer feeding the steering PID: settle heading,
// ramp up, cruise while counting lines, ramp down, then respond.
module move_seq
   import knight_pkg::*;
#(
   parameter bit          FAST_SIM   = 1'b0,
   parameter logic [9:0]  FRWRD_INC  = 10'h004,
   parameter logic [9:0]  MAX_SPD    = DEF_MAX_SPD,
   parameter logic [11:0] ERR_THRESH = DEF_ERR_THRESH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cmd,
   input  logic        cmd_rdy,
   output logic        clr_cmd_rdy,
   input  logic [11:0] heading,
   input  logic        heading_rdy,
   input  logic        cntrIR,
   output logic        moving,
   output logic        err_vld,
   output logic [11:0] error,
   output logic [9:0]  frwrd,
   output logic        send_resp
);

   localparam logic [9:0] STEP = FAST_SIM ? (FRWRD_INC << 3) : FRWRD_INC;

   move_state_t state;
   move_state_t state_nxt;

   logic [11:0] desired_heading;
   logic [3:0]  squares;
   logic [4:0]  line_cnt;
   logic        ir_ff;
   logic        ir_rise;
   logic        line_done;
   logic [11:0] err_raw;
   logic [11:0] err_abs;
   logic        settled;
   logic        accept;
   logic        reject;
   logic        counting;
   logic        at_max;
   logic        at_zero;
   logic        hit_max;

   assign err_vld   = heading_rdy;
   assign err_raw   = heading - desired_heading;
   assign error     = (state == ST_IDLE) ? 12'h000 : err_raw;
   assign err_abs   = err_raw[11] ? (~err_raw + 12'd1) : err_raw;
   assign settled   = err_abs < ERR_THRESH;
   assign ir_rise   = cntrIR & ~ir_ff;
   assign counting  = (state == ST_RAMP_UP) || (state == ST_CRUISE);
   assign line_done = line_cnt == {squares, 1'b0};

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      reject    = 1'b0;
      unique case (state)
         ST_IDLE:
            // clr_cmd_rdy guard stops a rejected command being seen twice
            if (cmd_rdy && !clr_cmd_rdy) begin
               if (cmd[15:12] == OP_MOVE) begin
                  accept    = 1'b1;
                  state_nxt = ST_SETTLE;
               end else begin
                  reject = 1'b1;
               end
            end
         ST_SETTLE:
            if (heading_rdy && settled)
               state_nxt = (squares == 4'h0) ? ST_RAMP_DN : ST_RAMP_UP;
         ST_RAMP_UP:
            if (line_done)
               state_nxt = ST_RAMP_DN;
            else if (hit_max)
               state_nxt = ST_CRUISE;
         ST_CRUISE:
            if (line_done)
               state_nxt = ST_RAMP_DN;
         ST_RAMP_DN:
            if (at_zero)
               state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         moving      <= 1'b0;
         clr_cmd_rdy <= 1'b0;
         send_resp   <= 1'b0;
      end else begin
         state       <= state_nxt;
         moving      <= state_nxt != ST_IDLE;
         clr_cmd_rdy <= accept | reject;
         send_resp   <= reject | ((state == ST_RAMP_DN) && at_zero);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         desired_heading <= 12'h000;
         squares         <= 4'h0;
      end else if (accept) begin
         desired_heading <= (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
         squares         <= cmd[3:0];
      end else if (state == ST_IDLE) begin
         desired_heading <= heading;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_ff    <= 1'b0;
         line_cnt <= 5'h00;
      end else begin
         ir_ff <= cntrIR;
         if (accept)
            line_cnt <= 5'h00;
         else if (counting && ir_rise && (line_cnt != 5'h1F))
            line_cnt <= line_cnt + 5'h01;
      end
   end

   frwrd_ramp #(
      .STEP    (STEP),
      .MAX_SPD (MAX_SPD)
   ) u_ramp (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (heading_rdy),
      .inc     ((state == ST_RAMP_UP) && !line_done),
      .dec     (state == ST_RAMP_DN),
      .clr     (state == ST_IDLE),
      .frwrd   (frwrd),
      .at_max  (at_max),
      .at_zero (at_zero),
      .hit_max (hit_max)
   );

endmodule

// File: doc/move_seq.md
# move_seq

Move sequencer that drives the steering PID controller for a single knight-move leg. It accepts a decoded move command, produces the PID's `moving`, `err_vld`, `error` and `frwrd` inputs, and sequences four phases: heading settle, forward ramp-up, cruise with line counting, and ramp-down. It sits between the command processor and the PID block and returns a one-cycle completion pulse.

## Interface
- `FAST_SIM`, default 0: when 1, ramp increment ×8, so simulations ramp fast.
- `FRWRD_INC`, default 10'h004: `frwrd` step per `heading_rdy` during ramp-up. Ramp-down uses 2×step.
- `MAX_SPD`, default 10'h2A0: cruise forward speed.
- `ERR_THRESH`, default 12'h030: |error| below this counts as "heading settled".
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd`  in  16  command word: [15:12] opcode (4'h2 = MOVE), [11:4] heading, [3:0] squares.
- `cmd_rdy`  in  1  command valid; level, held until cleared.
- `clr_cmd_rdy`  out  1  one-cycle pulse when `cmd` is consumed.
- `heading`  in  12  signed gyro heading.
- `heading_rdy`  in  1  one-cycle strobe; a new `heading` sample is valid.
- `cntrIR`  in  1  centre IR line sensor (asynchronous-safe, already synchronised).
- `moving`  out  1  PID enable.
- `err_vld`  out  1  equals `heading_rdy` (combinational pass-through).
- `error`  out  12  signed `heading − desired_heading`, 12-bit wrap.
- `frwrd`  out  10  unsigned forward speed to PID.
- `send_resp`  out  1  one-cycle pulse on move completion or command rejection.

## Operation
- States: IDLE, SETTLE, RAMP_UP, CRUISE, RAMP_DN.
- **IDLE**
  - `moving`=0 and `frwrd`=0.
  - When `cmd_rdy`=1 and opcode==MOVE:
    - latch `desired_heading` = (`cmd[11:4]`==0) ? 12'h000 : {`cmd[11:4]`, 4'hF};
    - latch `squares` = `cmd[3:0]`;
    - clear the line counter;
    - pulse `clr_cmd_rdy`;
    - go to SETTLE.
  - Bad opcode: pulse `clr_cmd_rdy` and `send_resp` in the same cycle, stay in IDLE.
- **SETTLE**
  - `moving`=1, `frwrd` held at 0.
  - On `heading_rdy` with signed |error| < ERR_THRESH:
    - if `squares`==0, go to RAMP_DN (it completes immediately since `frwrd`=0);
    - otherwise go to RAMP_UP.
- **RAMP_UP**
  - On each `heading_rdy`, `frwrd` += step, saturating at MAX_SPD.
  - When the updated value equals MAX_SPD, go to CRUISE.
- **CRUISE**
  - `frwrd` held.
- **Line counting** (RAMP_UP and CRUISE)
  - Each rising edge of `cntrIR` increments a 5-bit line counter.
  - When the counter reaches 2×`squares`, go to RAMP_DN. This applies from RAMP_UP as well, for short moves.
- **RAMP_DN**
  - On each `heading_rdy`, `frwrd` −= 2×step, saturating at 0.
  - When `frwrd`==0, pulse `send_resp`, drop `moving`, return to IDLE.
- **Steering**: `error` is always computed from the latched `desired_heading`. It is 0 in IDLE, because `desired_heading` tracks `heading` there.
- **Other commands**: `cmd_rdy` is ignored outside IDLE; no `clr_cmd_rdy` is issued.

## Timing
- Reset values: `frwrd`=0, `moving`=0, `clr_cmd_rdy`=0, `send_resp`=0, state=IDLE, counter=0, `desired_heading`=0.
- `clr_cmd_rdy` is registered. It is high the cycle after `cmd_rdy` is sampled in IDLE, and for exactly one cycle.
- `frwrd` and state update on the clock edge following a `heading_rdy` cycle.
- `moving` is registered and follows state (high in SETTLE, RAMP_UP, CRUISE, RAMP_DN).
- `cntrIR` edge detect uses one flop; the counter increments one cycle after the rise.
- Simultaneous events:
  - If the line target is reached in the same cycle as a `heading_rdy` in RAMP_UP, RAMP_DN wins and `frwrd` is not incremented.
  - `send_resp` rises the cycle after `frwrd` becomes 0.
- Counter saturates at 31; `squares` ≤ 15 guarantees no wrap.
- Asynchronous reset mid-move returns all outputs to reset values immediately.

## Structure
- Shared package `knight_pkg`:
  - `move_state_t` enum;
  - opcode constant `OP_MOVE` = 4'h2;
  - default `MAX_SPD` and `ERR_THRESH`.
- One sub-module `frwrd_ramp`: saturating up/down accumulator, enabled by `heading_rdy`, with inputs inc/dec/clr and outputs `frwrd` and `at_max`/`at_zero` flags.

## Test plan
1. After reset, `cmd`=16'h2FF1 with `cmd_rdy`=1 → one-cycle `clr_cmd_rdy`, `moving`=1, `desired_heading`=12'hFFF, `frwrd`=0 while |error| ≥ 12'h030.
2. `heading` driven to 12'hFF8 plus `heading_rdy` strobes → RAMP_UP; `frwrd` steps 0, 4, 8 … to 12'h2A0 (FAST_SIM=0), then holds.
3. Two `cntrIR` pulses with `squares`=1 → RAMP_DN; `frwrd` drops by 8 per strobe to 0; single `send_resp`; `moving`=0.
4. `cmd`=16'h2000 (0 squares) → settles, then immediate completion; `frwrd` never exceeds 0.
5. `cmd` opcode 4'h7 → `clr_cmd_rdy` and `send_resp` in the same cycle; `moving` stays 0.
6. `rst_n` asserted during CRUISE with `frwrd`=12'h2A0 → `frwrd`=0 and `moving`=0 without waiting for a clock; a new command is then accepted normally.
